// File: rtl/sipo_pkg.sv
// Shared definitions for the SIPO receive stage: FSM state encoding,
// default word width and bit-counter width helper.
package sipo_pkg;

    localparam int unsigned SIPO_WIDTH_DEF = 8;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } sipo_state_t;

    // Counter must hold values 0..WIDTH-1
    function automatic int unsigned sipo_cnt_w(input int unsigned width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/sipo_out_buf.sv
// Valid/ready holding register for assembled words, with overrun detection
// when a new word completes while the held word is not being consumed.
module sipo_out_buf
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH = SIPO_WIDTH_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_word,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_overrun
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_overrun;

    // Load on completion when empty or draining; otherwise drop and flag
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (i_load) begin
                if (!r_valid || i_ready) begin
                    r_data  <= i_word;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_data    = r_data;
    assign o_valid   = r_valid;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out receive stage: aligns on start marker, assembles
// WIDTH-bit words and hands them to a double-buffered valid/ready output.
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH     = SIPO_WIDTH_DEF,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ser_in,
    input  logic             ser_valid,
    input  logic             ser_start,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    output logic             frame_err,
    output logic             busy
);

    localparam int unsigned CNT_W = sipo_cnt_w(WIDTH);

    sipo_state_t      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_shift;
    logic             r_frame_err;

    sipo_state_t      w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] w_shift_nxt;
    logic [WIDTH-1:0] w_word;
    logic             w_complete;
    logic             w_frame_err;

    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                  input logic b);
        if (MSB_FIRST)
            return {cur[WIDTH-2:0], b};
        else
            return {b, cur[WIDTH-1:1]};
    endfunction

    // State, bit counter, shift register and frame-error pulse registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_frame_err <= w_frame_err;
        end
    end

    // Next-state, counter and shift-register logic
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_complete  = 1'b0;
        w_frame_err = 1'b0;
        w_word      = shift_in(r_shift, ser_in);
        case (r_state)
            S_IDLE: begin
                if (ser_valid && ser_start) begin
                    w_shift_nxt = shift_in('0, ser_in);
                    w_cnt_nxt   = CNT_W'(1);
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (ser_valid) begin
                    if (ser_start) begin
                        w_frame_err = 1'b1;
                        w_shift_nxt = shift_in('0, ser_in);
                        w_cnt_nxt   = CNT_W'(1);
                    end else if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        w_complete  = 1'b1;
                        w_shift_nxt = w_word;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_shift_nxt = w_word;
                        w_cnt_nxt   = r_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    sipo_out_buf #(
        .WIDTH(WIDTH)
    ) u_out_buf (
        .i_clk     (clk),
        .i_rst_n   (reset),
        .i_load    (w_complete),
        .i_word    (w_word),
        .i_ready   (out_ready),
        .o_data    (data_out),
        .o_valid   (out_valid),
        .o_overrun (overrun)
    );

    assign frame_err = r_frame_err;
    assign busy      = (r_state == S_SHIFT);

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer: MSB-first and LSB-first instances
// share one serial stream; delivered words are checked against a scoreboard.
module tb_sipo_deserializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, ser_in, ser_valid, ser_start, out_ready;
    logic [7:0] d_m, d_l;
    logic       v_m, v_l, ov_m, ov_l, fe_m, fe_l, b_m, b_l;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [7:0]  q_m[$];
    logic [7:0]  q_l[$];

    sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .reset(reset), .ser_in(ser_in), .ser_valid(ser_valid),
        .ser_start(ser_start), .data_out(d_m), .out_valid(v_m),
        .out_ready(out_ready), .overrun(ov_m), .frame_err(fe_m), .busy(b_m)
    );

    sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset(reset), .ser_in(ser_in), .ser_valid(ser_valid),
        .ser_start(ser_start), .data_out(d_l), .out_valid(v_l),
        .out_ready(out_ready), .overrun(ov_l), .frame_err(fe_l), .busy(b_l)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] w);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = w[7-i];
        return r;
    endfunction

    // Scoreboard: every accepted word must match the oldest expected one
    always @(negedge clk) begin
        if (v_m && out_ready) begin
            if (q_m.size() == 0) check("msb_unexpected_word", {24'h0, d_m}, 32'hFFFF_FFFF);
            else check("msb_word", {24'h0, d_m}, {24'h0, q_m.pop_front()});
        end
        if (v_l && out_ready) begin
            if (q_l.size() == 0) check("lsb_unexpected_word", {24'h0, d_l}, 32'hFFFF_FFFF);
            else check("lsb_word", {24'h0, d_l}, {24'h0, q_l.pop_front()});
        end
    end

    task automatic send_bit(input logic b, input logic st);
        ser_in    = b;
        ser_start = st;
        ser_valid = 1'b1;
        @(posedge clk);
        #1;
        ser_valid = 1'b0;
        ser_start = 1'b0;
        ser_in    = 1'b0;
    endtask

    // Bits go out w[7] first; start marker on the first bit
    task automatic send_stream(input logic [7:0] w, input int unsigned gap_max,
                               input bit push, input bit fe_exp,
                               input bit hold_chk, input bit ready_last);
        if (push) begin
            q_m.push_back(w);
            q_l.push_back(rev8(w));
        end
        for (int i = 7; i >= 0; i--) begin
            if (ready_last && i == 0) out_ready = 1'b1;
            send_bit(w[i], i == 7);
            if (i == 7) begin
                check("frame_err_at_start", {30'h0, fe_m, fe_l}, {30'h0, fe_exp, fe_exp});
                check("busy_after_start", {30'h0, b_m, b_l}, 32'h3);
            end else begin
                check("frame_err_quiet", {30'h0, fe_m, fe_l}, 32'h0);
            end
            if (hold_chk) check("valid_held", {30'h0, v_m, v_l}, 32'h3);
            if (i > 0) begin
                int unsigned g;
                g = $urandom_range(gap_max, 0);
                repeat (g) begin
                    @(posedge clk);
                    #1;
                    if (hold_chk) check("valid_held_gap", {30'h0, v_m, v_l}, 32'h3);
                end
            end
        end
        if (ready_last) out_ready = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        ser_in    = 1'b0;
        ser_valid = 1'b0;
        ser_start = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_msb", {20'h0, d_m, v_m, ov_m, fe_m, b_m}, 32'h0);
        check("reset_lsb", {20'h0, d_l, v_l, ov_l, fe_l, b_l}, 32'h0);
        reset = 1'b1;

        // 1: reset mid-word, then unstarted bits are ignored
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        check("busy_mid_word", {30'h0, b_m, b_l}, 32'h3);
        #2 reset = 1'b0;
        #1;
        check("async_reset_msb", {20'h0, d_m, v_m, ov_m, fe_m, b_m}, 32'h0);
        check("async_reset_lsb", {20'h0, d_l, v_l, ov_l, fe_l, b_l}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        out_ready = 1'b1;
        repeat (8) send_bit(1'b1, 1'b0);
        check("no_word_without_start", {28'h0, v_m, v_l, b_m, b_l}, 32'h0);

        // 2/3: stream 1,0,1,0,0,1,0,1 then 1,1,0,0,0,0,0,0
        send_stream(8'hA5, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("a5_valid_latency", {30'h0, v_m, v_l}, 32'h3);
        check("a5_msb_data", {24'h0, d_m}, 32'hA5);
        check("a5_lsb_data", {24'h0, d_l}, 32'hA5);
        check("busy_after_word", {30'h0, b_m, b_l}, 32'h0);
        @(posedge clk);
        #1;
        check("a5_valid_drops", {30'h0, v_m, v_l}, 32'h0);
        send_stream(8'hC0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("c0_msb_data", {24'h0, d_m}, 32'hC0);
        check("c0_lsb_data", {24'h0, d_l}, 32'h03);
        @(posedge clk);
        #1;

        // 4: overrun with held word
        out_ready = 1'b0;
        send_stream(8'h3C, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        send_stream(8'hF0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("overrun_pulse", {30'h0, ov_m, ov_l}, 32'h3);
        check("overrun_keeps_msb", {24'h0, d_m}, 32'h3C);
        check("overrun_keeps_lsb", {24'h0, d_l}, {24'h0, rev8(8'h3C)});
        @(posedge clk);
        #1;
        check("overrun_one_cycle", {30'h0, ov_m, ov_l}, 32'h0);
        check("still_valid", {30'h0, v_m, v_l}, 32'h3);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("drain_clears_valid", {30'h0, v_m, v_l}, 32'h0);
        check("data_not_cleared", {24'h0, d_m}, 32'h3C);

        // 5: restart mid-word
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_stream(8'h96, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("96_msb_data", {24'h0, d_m}, 32'h96);
        check("96_valid", {30'h0, v_m, v_l}, 32'h3);
        check("no_overrun_on_fe", {30'h0, ov_m, ov_l}, 32'h0);
        @(posedge clk);
        #1;

        // 6: gapped bits, accept-and-load keeps out_valid high
        out_ready = 1'b0;
        send_stream(8'h01, 3, 1'b1, 1'b0, 1'b0, 1'b0);
        send_stream(8'hFF, 3, 1'b1, 1'b0, 1'b1, 1'b1);
        check("ff_no_overrun", {30'h0, ov_m, ov_l}, 32'h0);
        check("ff_msb_data", {24'h0, d_m}, 32'hFF);
        @(posedge clk);
        #1;
        check("ff_still_held", {30'h0, v_m, v_l}, 32'h3);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("ff_drained", {30'h0, v_m, v_l}, 32'h0);
        out_ready = 1'b0;

        check("msb_queue_empty", q_m.size(), 32'h0);
        check("lsb_queue_empty", q_l.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
